// File: rtl/gray_counter_bin2gray.sv
// Combinational binary to reflected-binary Gray encoder.
// Exact inverse of the downstream Gray-to-binary converter.
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    always_comb begin
        gray = bin ^ (bin >> 1);
    end

endmodule

// File: rtl/gray_counter.sv
// Synchronous up/down counter with registered Gray-code output and a one-cycle
// terminal-count pulse on every wrap. Priority per edge: rst > load > en > hold.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] load_gray;
    logic [WIDTH-1:0] step_gray;
    logic             wrap;

    // Next count and wrap detection depend only on the current binary state,
    // so gray_out stays a pure flop output.
    always_comb begin
        bin_next = up_dn ? (bin_q + ONE) : (bin_q - ONE);
        wrap     = up_dn ? (&bin_q) : (~|bin_q);
    end

    bin2gray #(.WIDTH(WIDTH)) u_load_enc (
        .bin  (load_bin),
        .gray (load_gray)
    );

    bin2gray #(.WIDTH(WIDTH)) u_step_enc (
        .bin  (bin_next),
        .gray (step_gray)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q    <= '0;
            gray_out <= '0;
            tc       <= 1'b0;
        end else if (load) begin
            bin_q    <= load_bin;
            gray_out <= load_gray;
            tc       <= 1'b0;
        end else if (en) begin
            bin_q    <= bin_next;
            gray_out <= step_gray;
            tc       <= wrap;
        end else begin
            tc       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed scenarios plus a randomized
// run checked through a Gray-to-binary conversion against an integer count model.
module tb_gray_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] gray_out;
    logic         tc;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer count and expected terminal-count flag.
    int m_cnt = 0;
    bit m_tc  = 1'b0;

    gray_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_bin (load_bin),
        .gray_out (gray_out),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    function automatic int gray2bin(input logic [W-1:0] g);
        int b = 0;
        bit acc = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            acc = acc ^ g[i];
            if (acc) b = b + (1 << i);
        end
        return b;
    endfunction

    function automatic int hamming(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        for (int i = 0; i < W; i++) if (a[i] != b[i]) n++;
        return n;
    endfunction

    // Drive one cycle of inputs away from the edge, then sample #1 after it.
    task automatic cycle(input bit r, input bit l, input int lb, input bit e, input bit u);
        @(negedge clk);
        rst      = r;
        load     = l;
        load_bin = W'(lb);
        en       = e;
        up_dn    = u;
        @(posedge clk);
        #1;
        if (r) begin
            m_cnt = 0; m_tc = 1'b0;
        end else if (l) begin
            m_cnt = lb % MOD; m_tc = 1'b0;
        end else if (e) begin
            if (u) begin
                m_tc  = (m_cnt == MOD - 1);
                m_cnt = (m_cnt + 1) % MOD;
            end else begin
                m_tc  = (m_cnt == 0);
                m_cnt = (m_cnt + MOD - 1) % MOD;
            end
        end else begin
            m_tc = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1, 1, 5, 1, 1);
            checks++;
            if (gray_out !== 4'b0000 || tc !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset edge %0d: gray_out=%b tc=%b, required 0000/0", i, gray_out, tc);
            end
        end
    endtask

    task automatic test_up_count();
        logic [W-1:0] exp_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                       4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                       4'b1011, 4'b1001, 4'b1000, 4'b0000};
        logic [W-1:0] prev;
        int tc_count = 0;
        cycle(1, 0, 0, 0, 1);
        prev = gray_out;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 0, 1, 1);
            checks++;
            if (gray_out !== exp_seq[i] || tc !== (i == 15)) begin
                errors++;
                $display("[TB] FAIL up_count step %0d: gray_out=%b tc=%b, required %b/%0d",
                         i, gray_out, tc, exp_seq[i], (i == 15));
            end
            checks++;
            if (hamming(prev, gray_out) != 1) begin
                errors++;
                $display("[TB] FAIL up_hamming step %0d: %b -> %b, required distance 1", i, prev, gray_out);
            end
            if (tc === 1'b1) tc_count++;
            prev = gray_out;
        end
        checks++;
        if (tc_count != 1) begin
            errors++;
            $display("[TB] FAIL up_tc_count: %0d pulses in 16 steps, required 1", tc_count);
        end
    endtask

    task automatic test_down_wrap();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        checks++;
        if (gray_out !== 4'b1000 || tc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL down_wrap: gray_out=%b tc=%b, required 1000/1", gray_out, tc);
        end
        cycle(0, 0, 0, 1, 0);
        checks++;
        if (gray_out !== 4'b1001 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL down_after_wrap: gray_out=%b tc=%b, required 1001/0", gray_out, tc);
        end
    endtask

    task automatic test_load_priority();
        cycle(0, 1, 5, 1, 1);
        checks++;
        if (gray_out !== 4'b0111 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_over_en: gray_out=%b tc=%b, required 0111/0", gray_out, tc);
        end
        cycle(0, 0, 0, 1, 1);
        checks++;
        if (gray_out !== 4'b0101 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step_after_load: gray_out=%b tc=%b, required 0101/0", gray_out, tc);
        end
        cycle(1, 1, 9, 1, 1);
        checks++;
        if (gray_out !== 4'b0000 || tc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_over_load: gray_out=%b tc=%b, required 0000/0", gray_out, tc);
        end
        // Loading all ones must not arm tc; the following up step wraps and must.
        cycle(0, 1, 15, 0, 1);
        cycle(0, 0, 0, 1, 1);
        checks++;
        if (gray_out !== 4'b0000 || tc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_after_load: gray_out=%b tc=%b, required 0000/1", gray_out, tc);
        end
    endtask

    task automatic test_hold_direction();
        cycle(0, 1, 4, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, i[0]);
            checks++;
            if (gray_out !== 4'b0110 || tc !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold cycle %0d: gray_out=%b tc=%b, required 0110/0", i, gray_out, tc);
            end
        end
        cycle(0, 0, 0, 1, 0);
        checks++;
        if (gray_out !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL dir_down: gray_out=%b, required 0010", gray_out);
        end
        cycle(0, 0, 0, 1, 1);
        checks++;
        if (gray_out !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL dir_up: gray_out=%b, required 0110", gray_out);
        end
    endtask

    task automatic test_random_end_to_end();
        logic [W-1:0] prev;
        bit r, l, e, u;
        int lb;
        cycle(1, 0, 0, 0, 0);
        prev = gray_out;
        for (int i = 0; i < 40; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1);
            lb = $urandom_range(0, MOD - 1);
            cycle(r, l, lb, e, u);
            checks++;
            if (gray2bin(gray_out) != m_cnt || tc !== m_tc) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: decoded=%0d tc=%b, required %0d/%0d",
                         i, gray2bin(gray_out), tc, m_cnt, m_tc);
            end
            if (!r && !l && e) begin
                checks++;
                if (hamming(prev, gray_out) != 1) begin
                    errors++;
                    $display("[TB] FAIL random_hamming cycle %0d: %b -> %b, required distance 1",
                             i, prev, gray_out);
                end
            end
            prev = gray_out;
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load_priority();
        test_hold_direction();
        test_random_end_to_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous up/down counter that emits its count directly in reflected-binary Gray code.
- Sits directly upstream of the team's Gray-to-binary converter. Its gray_out drives that converter's inputs, MSB first.
- Downstream logic and CDC paths get a registered, glitch-free, single-bit-change code every step.

Parameters:
- WIDTH, 4, counter and Gray code width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; one step per clk edge while high
- up_dn  input  1  direction: 1 = count up, 0 = count down
- load  input  1  synchronous load strobe
- load_bin  input  WIDTH  binary value applied on load
- gray_out  output  WIDTH  registered Gray code of current count; bit WIDTH-1 is MSB
- tc  output  1  registered terminal-count pulse, high for one cycle after a wrap

Behaviour:
- Single clock. Reset is synchronous and active-high on rst; all state changes occur on the rising edge of clk.
- Internal state:
  - bin_q, WIDTH bits, binary count, not exported.
  - gray_out register.
  - tc register.
- Reset values: bin_q = 0, gray_out = 0, tc = 0.
- Priority each edge: rst > load > en > hold.
- Load:
  - bin_q <= load_bin
  - gray_out <= load_bin ^ (load_bin >> 1)
  - tc <= 0
  - en and up_dn are ignored that cycle.
- Enabled step, up_dn = 1:
  - bin_next = bin_q + 1 mod 2^WIDTH
  - tc <= 1 iff bin_q is all ones, i.e. the count wraps to 0.
- Enabled step, up_dn = 0:
  - bin_next = bin_q - 1 mod 2^WIDTH
  - tc <= 1 iff bin_q == 0, i.e. the count wraps to all ones.
- On an enabled step: bin_q <= bin_next and gray_out <= bin2gray(bin_next).
- Hold (en = 0, no load, no rst):
  - bin_q and gray_out unchanged.
  - tc <= 0.
- Latency: gray_out reflects a step or load one clk edge after the edge that samples en or load.
- Gray property: on consecutive enabled steps, gray_out changes in exactly one bit. This holds at wrap-around in both directions.
- Direction change (up_dn toggles between enabled cycles) takes effect on the next step with no dead cycle. The single-bit-change property still holds.
- tc stays high for exactly one cycle per wrap. When en is held continuously, tc pulses once every 2^WIDTH steps.
- Reset mid-count: the next edge forces 0/0/0 regardless of en or load. Counting resumes from 0 on the following enabled edge.
- gray_out is driven from a flop only; no combinational path from inputs to outputs.

Decomposition:
- No shared package needed; WIDTH is the only constant.
- One natural sub-module: bin2gray, combinational, WIDTH-parameterised, computing g = b ^ (b >> 1).
  - Instantiate it twice: once on load_bin, once on bin_next.
  - It is the exact inverse of the downstream converter.

Test Plan (WIDTH = 4):
- Reset: assert rst 2 cycles with en = 1 and load = 1 → gray_out = 0000, tc = 0 at every edge while rst is high.
- Up count: en = 1, up_dn = 1 for 16 edges from 0 → gray_out sequence is 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - tc = 1 only in the cycle gray_out returns to 0000.
  - Hamming distance between successive values is 1.
- Down wrap: from reset, en = 1, up_dn = 0 for one edge → gray_out = 1000, tc = 1. Next edge → 1001, tc = 0.
- Load and priority:
  - load = 1, load_bin = 0101, en = 1 in the same cycle → gray_out = 0111, tc = 0.
  - Then one up step → 0101 (binary 6).
  - load and rst together → 0000.
- Hold and direction change:
  - en = 0 for 5 cycles at gray 0110 → output stays 0110, tc = 0.
  - Toggle up_dn each enabled edge → 0110 → 0010 → 0110.
- End-to-end: drive gray_out into the Gray-to-binary converter, run 40 random en/up_dn/load cycles → converter output equals the reference model's binary count every cycle.
